// File: rtl/program_memory_loader_if.sv
// -----------------------------------------------------------------------------
// program_memory_loader_if
// Bundles the instruction-fetch read port and the byte-serial loader port of
// program_memory_loader.
//   PC           : fetch address from control_unit
//   PM_data      : instruction word at PC (zero while the core is held)
//   load_start   : one-cycle pulse that begins or restarts a load
//   byte_in      : loader data byte
//   byte_valid   : byte_in qualifier, no backpressure
//   cpu_hold     : core halt request while loading or after a failed load
//   load_done    : one-cycle pulse when the image has been fully written
//   load_error   : sticky error flag
//   words_loaded : data words written by the current or last load
// Modports: master = fetch unit / byte source side, slave = loader/memory.
// -----------------------------------------------------------------------------
interface program_memory_loader_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] PC;
    logic [15:0]         PM_data;
    logic                load_start;
    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                cpu_hold;
    logic                load_done;
    logic                load_error;
    logic [PC_WIDTH:0]   words_loaded;

    modport master (
        output PC, load_start, byte_in, byte_valid,
        input  PM_data, cpu_hold, load_done, load_error, words_loaded
    );

    modport slave (
        input  PC, load_start, byte_in, byte_valid,
        output PM_data, cpu_hold, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/program_memory_loader.sv
// -----------------------------------------------------------------------------
// program_memory_loader
// 2**PC_WIDTH x 16-bit program memory with a combinational fetch port and a
// byte-serial loader. The load stream is a big-endian 16-bit word count N
// followed by N big-endian instruction words, written from address 0 upward.
// While a load is running (or after it failed) cpu_hold is high and the fetch
// port returns 16'h0000.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high; memory contents are not cleared
//   bus   : program_memory_loader_if.slave (fetch port + loader port)
// Optional feature: define LOADER_TIMEOUT_EN to abort a load with an error
// after TIMEOUT_CYCLES consecutive cycles without byte_valid while waiting
// for stream bytes. Without it the loader waits indefinitely.
// -----------------------------------------------------------------------------
module program_memory_loader #(
    parameter int PC_WIDTH       = 8,
    parameter int MAX_WORDS      = 2**PC_WIDTH,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    program_memory_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_HI  = 3'd1,
        HDR_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;

    // Elaboration-time guard: an image larger than the memory would wrap.
    if ((MAX_WORDS > (2**PC_WIDTH)) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_error
        $error("program_memory_loader: MAX_WORDS or TIMEOUT_CYCLES out of range");
    end

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;          // shared high-byte latch
    logic [15:0]         hdr_q, hdr_d;        // image length N
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH:0]   words_q, words_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_done_q, load_done_d;
    logic                load_error_q, load_error_d;

    logic [15:0]         mem_q [2**PC_WIDTH];
    logic                mem_we_s;
    logic [15:0]         word_s;              // {latched high byte, incoming byte}
    logic                timeout_s;

    assign word_s = {hi_q, bus.byte_in};

`ifdef LOADER_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              wait_state_s;

    assign wait_state_s = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                          (state_q == DATA_HI) || (state_q == DATA_LO);

    // Idle-cycle counter: every state entry is caused by byte_valid or
    // load_start, so clearing on those also covers the clear-on-entry rule.
    always_comb begin
        idle_d    = idle_q;
        timeout_s = 1'b0;
        if (bus.load_start || bus.byte_valid || !wait_state_s) begin
            idle_d = {IDLE_W{1'b0}};
        end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_s = 1'b1;
            idle_d    = {IDLE_W{1'b0}};
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Idle-cycle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_q <= {IDLE_W{1'b0}};
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Loader next-state and datapath; load_start overrides everything,
    // including a byte arriving in the same cycle.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        hdr_d        = hdr_q;
        addr_d       = addr_q;
        words_d      = words_q;
        cpu_hold_d   = cpu_hold_q;
        load_error_d = load_error_q;
        load_done_d  = 1'b0;
        mem_we_s     = 1'b0;

        if (bus.load_start) begin
            state_d      = HDR_HI;
            cpu_hold_d   = 1'b1;
            load_error_d = 1'b0;
            words_d      = {(PC_WIDTH+1){1'b0}};
            addr_d       = {PC_WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                HDR_HI, DATA_HI: begin
                    if (bus.byte_valid) begin
                        hi_d    = bus.byte_in;
                        state_d = (state_q == HDR_HI) ? HDR_LO : DATA_LO;
                    end else if (timeout_s) begin
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                HDR_LO: begin
                    if (bus.byte_valid) begin
                        hdr_d = word_s;
                        if (word_s == 16'h0000) begin
                            state_d = DONE;
                        end else if (32'(word_s) > 32'(MAX_WORDS)) begin
                            state_d      = ERROR;
                            load_error_d = 1'b1;
                        end else begin
                            state_d = DATA_HI;
                        end
                    end else if (timeout_s) begin
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                DATA_LO: begin
                    if (bus.byte_valid) begin
                        mem_we_s = 1'b1;
                        addr_d   = addr_q + PC_WIDTH'(1);
                        words_d  = words_q + (PC_WIDTH+1)'(1);
                        // Compare against the pre-increment count plus one.
                        if ((32'(words_q) + 32'd1) == 32'(hdr_q)) begin
                            state_d = DONE;
                        end else begin
                            state_d = DATA_HI;
                        end
                    end else if (timeout_s) begin
                        state_d      = ERROR;
                        load_error_d = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    cpu_hold_d = 1'b0;
                end
                ERROR: begin
                    state_d      = ERROR;
                    cpu_hold_d   = 1'b1;
                    load_error_d = 1'b1;
                end
                default: begin
                    state_d    = IDLE;
                    cpu_hold_d = 1'b0;
                end
            endcase
        end

        // Registered decode so load_done is high exactly while in DONE.
        load_done_d = (state_d == DONE);
    end

    // Loader state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            hi_q         <= 8'h00;
            hdr_q        <= 16'h0000;
            addr_q       <= {PC_WIDTH{1'b0}};
            words_q      <= {(PC_WIDTH+1){1'b0}};
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            hdr_q        <= hdr_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    // Single write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= word_s;
        end
    end

    assign bus.PM_data      = cpu_hold_q ? 16'h0000 : mem_q[bus.PC];
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_error   = load_error_q;
    assign bus.words_loaded = words_q;

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Program memory for the CPU core, plus a byte-serial loader that writes a program image into it.
- Sits directly upstream of control_unit:
  - control_unit drives PC.
  - This block returns PM_data in the same cycle.
- Loading uses a length-prefixed byte stream, e.g. from a UART receiver. While loading, cpu_hold is asserted so the core stays halted.

Parameters:
- PC_WIDTH, 8, program counter/address width. Memory depth is 2**PC_WIDTH words of 16 bits.
- MAX_WORDS, 2**PC_WIDTH, largest accepted image length. Must be <= 2**PC_WIDTH.
- TIMEOUT_CYCLES, 1000, idle-byte limit used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- PC  input  PC_WIDTH  read address from control_unit.
- PM_data  output  16  instruction at mem[PC]; combinational read.
- load_start  input  1  one-cycle pulse; begins or restarts a load.
- byte_in  input  8  loader data byte.
- byte_valid  input  1  byte_in is valid this cycle. Single-cycle qualifier, no backpressure.
- cpu_hold  output  1  high while a load is in progress or has failed; drives the core's reset.
- load_done  output  1  one-cycle pulse when the image has been fully written.
- load_error  output  1  sticky error flag.
- words_loaded  output  PC_WIDTH+1  count of data words written in the current or last load.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - cpu_hold = 0, load_done = 0, load_error = 0, words_loaded = 0.
  - Internal address counter = 0; header register = 0; high-byte latch = 0.
  - Memory contents are not cleared.
- Read path: PM_data = mem[PC] combinationally whenever cpu_hold = 0. When cpu_hold = 1, PM_data = 16'h0000.
- Stream format, all values big-endian:
  - Header word: N, high byte first.
  - Followed by N instruction words, each high byte first. Opcode sits in bits [15:11].
- FSM states: IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, DONE, ERROR.
- IDLE:
  - byte_valid is ignored.
  - load_start -> HDR_HI. Same edge: cpu_hold <= 1, load_error <= 0, words_loaded <= 0, address <= 0.
- HDR_HI: on byte_valid, latch the high byte -> HDR_LO.
- HDR_LO: on byte_valid, form N = {hi, byte_in}.
  - N == 0 -> DONE.
  - N > MAX_WORDS -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI: on byte_valid, latch the high byte -> DATA_LO.
- DATA_LO: on byte_valid:
  - Write mem[address] <= {hi, byte_in}.
  - address += 1; words_loaded += 1.
  - If words_loaded + 1 == N -> DONE, else -> DATA_HI.
  - The write is visible on PM_data the cycle after cpu_hold falls.
- DONE: lasts exactly one cycle.
  - load_done = 1 during this cycle.
  - cpu_hold <= 0 at the end of the cycle.
  - Then -> IDLE.
- ERROR:
  - cpu_hold = 1 and load_error = 1, held.
  - Exits only on load_start (-> HDR_HI) or reset.
- Address boundary: address never exceeds N-1, because N <= MAX_WORDS <= 2**PC_WIDTH, so no wrap occurs. Bytes arriving after DONE land in IDLE and are ignored.
- load_start outside IDLE and ERROR (including in DONE):
  - Restarts at HDR_HI; the current load is abandoned.
  - Memory already written is kept; words_loaded <= 0.
  - load_start has priority over a same-cycle byte_valid, and that byte is discarded.
- Reset mid-load: returns to IDLE with cpu_hold = 0. Partially written memory remains.
- At most one memory write per cycle; there is a single write port.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in the HDR_HI, HDR_LO, DATA_HI and DATA_LO states.
  - It clears on byte_valid or on a state entry.
  - Reaching TIMEOUT_CYCLES consecutive cycles without byte_valid -> ERROR (cpu_hold = 1, load_error = 1).
- Not defined: no counter; the loader waits indefinitely for bytes.

Test Plan:
- Basic load:
  - Stimulus: reset 1 cycle; load_start; bytes 00 02 B3 05 B4 07.
  - Required: load_done pulses once; words_loaded = 2; cpu_hold falls.
  - Then PC = 0 -> PM_data = 16'hB305 (MOVI R3, #5); PC = 1 -> 16'hB407.
- Hold and read masking:
  - Stimulus: mid-load, after the header only, drive PC = 0.
  - Required: PM_data = 16'h0000 and cpu_hold = 1 until load_done.
- Zero length:
  - Stimulus: load_start; bytes 00 00.
  - Required: load_done pulses the cycle after the second byte; words_loaded = 0; memory unchanged.
- Oversize:
  - Stimulus: PC_WIDTH = 8; header bytes 01 01 (N = 257).
  - Required: load_error = 1 and cpu_hold = 1, held.
  - Then load_start with bytes 00 01 12 34: error clears; mem[0] = 16'h1234.
- Restart and priority:
  - Stimulus: during DATA_LO, assert load_start together with byte_valid.
  - Required: FSM enters HDR_HI; the byte is not written; words_loaded = 0.
  - A subsequent full stream completes normally.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYCLES = 20):
  - Stimulus: load_start; bytes 00 03 then silence.
  - Required: load_error rises exactly 20 cycles after the last byte.
  - Without the macro: still in DATA_HI after 100 cycles, load_error = 0.
